// File: rtl/free_list_checkpoint_stack.sv
// Branch checkpoint stack for the Free_List: snapshots the free list per dispatched branch,
// keeps snapshots current with retired T_old, and drives the restore pulse on a mispredict.
module free_list_checkpoint_stack #(
  parameter  int NUM_PHYS_REG = 64,
  parameter  int NUM_CKPT     = 4,
  localparam int PHYS_REG     = $clog2(NUM_PHYS_REG) + 1,
  localparam int TAIL_W       = $clog2(NUM_PHYS_REG) + 1,
  localparam int TAG_W        = $clog2(NUM_CKPT),
  localparam int LIST_W       = PHYS_REG * NUM_PHYS_REG
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ckpt_en,
  input  logic [LIST_W-1:0]   free_list_in,
  input  logic [TAIL_W-1:0]   tail_in,
  input  logic                retire_en,
  input  logic [PHYS_REG-1:0] retire_T_old,
  input  logic                resolve_en,
  input  logic [TAG_W-1:0]    resolve_tag,
  input  logic                resolve_mispred,
  output logic [TAG_W-1:0]    ckpt_tag,
  output logic                full,
  output logic                empty,
  output logic                branch_incorrect,
  output logic [LIST_W-1:0]   free_check_point,
  output logic [TAIL_W-1:0]   tail_check_point
);

  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [NUM_CKPT-1:0] done_q, done_d;
  logic [LIST_W-1:0]   list_q [NUM_CKPT];
  logic [LIST_W-1:0]   list_d [NUM_CKPT];
  logic [TAIL_W-1:0]   tail_q [NUM_CKPT];
  logic [TAIL_W-1:0]   tail_d [NUM_CKPT];
  logic [TAG_W-1:0]    head_q, head_d;
  logic [TAG_W-1:0]    alloc_q, alloc_d;
  logic                bi_q, bi_d;
  logic [LIST_W-1:0]   fcp_q, fcp_d;
  logic [TAIL_W-1:0]   tcp_q, tcp_d;

  logic                mispred;
  logic                advance;
  logic [TAG_W-1:0]    age_t;

  assign full             = &valid_q;
  assign empty            = ~|valid_q;
  assign ckpt_tag         = alloc_q;
  assign branch_incorrect = bi_q;
  assign free_check_point = fcp_q;
  assign tail_check_point = tcp_q;

  assign mispred = resolve_en & resolve_mispred & valid_q[resolve_tag];
  assign age_t   = TAG_W'(resolve_tag - head_q);

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    list_d  = list_q;
    tail_d  = tail_q;
    head_d  = head_q;
    alloc_d = alloc_q;
    bi_d    = 1'b0;
    fcp_d   = fcp_q;
    tcp_d   = tcp_q;
    advance = 1'b1;

    // A mispredict flushes the path this dispatch came from, so its capture is dropped.
    if (ckpt_en && !full && !mispred) begin
      list_d[alloc_q]  = free_list_in;
      tail_d[alloc_q]  = tail_in;
      valid_d[alloc_q] = 1'b1;
      done_d[alloc_q]  = 1'b0;
      alloc_d          = alloc_q + TAG_W'(1);
    end

    if (retire_en) begin
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        if (valid_d[s] && tail_d[s] < TAIL_W'(NUM_PHYS_REG)) begin
          list_d[s][PHYS_REG*int'(tail_d[s]) +: PHYS_REG] = retire_T_old;
          tail_d[s] = tail_d[s] + TAIL_W'(1);
        end
      end
    end

    if (mispred) begin
      bi_d  = 1'b1;
      fcp_d = list_d[resolve_tag];
      tcp_d = tail_d[resolve_tag];
      // Age is distance from head, so "t and younger" is everything at or past t's age.
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        if (valid_q[s] && TAG_W'(TAG_W'(s) - head_q) >= age_t) begin
          valid_d[s] = 1'b0;
          done_d[s]  = 1'b0;
        end
      end
      alloc_d = resolve_tag;
    end else if (resolve_en && !resolve_mispred && valid_q[resolve_tag]) begin
      done_d[resolve_tag] = 1'b1;
    end

    for (int unsigned k = 0; k < NUM_CKPT; k++) begin
      if (advance && valid_d[head_d] && done_d[head_d]) begin
        valid_d[head_d] = 1'b0;
        done_d[head_d]  = 1'b0;
        head_d          = head_d + TAG_W'(1);
      end else begin
        advance = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      alloc_q <= '0;
      bi_q    <= 1'b0;
      fcp_q   <= '0;
      tcp_q   <= '0;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        list_q[s] <= '0;
        tail_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      alloc_q <= alloc_d;
      bi_q    <= bi_d;
      fcp_q   <= fcp_d;
      tcp_q   <= tcp_d;
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        list_q[s] <= list_d[s];
        tail_q[s] <= tail_d[s];
      end
    end
  end

endmodule
